// File: rtl/lib_sa_pkg.sv
// Shared constants for the library signature analyzer.
// State codes, default MISR settings and response bit positions.
package lib_sa_pkg;

  localparam logic [1:0] SA_IDLE = 2'd0;
  localparam logic [1:0] SA_RUN  = 2'd1;
  localparam logic [1:0] SA_CMP  = 2'd2;
  localparam logic [1:0] SA_DONE = 2'd3;

  localparam logic [15:0] SA_SEED_DEF = 16'hFFFF;
  localparam logic [15:0] SA_POLY_DEF = 16'h1021;
  localparam int          SA_TO_DEF   = 16;

  localparam int RESP_W   = 5;
  localparam int RESP_QP  = 0;
  localparam int RESP_MUX = 1;
  localparam int RESP_NOT = 2;
  localparam int RESP_NOR = 3;
  localparam int RESP_NAND = 4;

endpackage

// File: rtl/lib_misr.sv
// Galois-form multiple-input signature register.
// load_i reseeds, en_i absorbs one response sample.
module lib_misr
  import lib_sa_pkg::*;
#(
  parameter int                SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = SIG_W'(SA_POLY_DEF),
  parameter logic [SIG_W-1:0]  SEED  = SIG_W'(SA_SEED_DEF)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [RESP_W-1:0] data_i,
  output logic [SIG_W-1:0]  sig_o
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] shf;

  // shift with polynomial feedback, then fold in the sample
  always_comb begin
    shf   = {sig_q[SIG_W-2:0], 1'b0};
    shf   = shf ^ (sig_q[SIG_W-1] ? POLY : '0);
    sig_d = sig_q;
    if (load_i)
      sig_d = SEED;
    else if (en_i)
      sig_d = shf ^ {{(SIG_W-RESP_W){1'b0}}, data_i};
  end

  // signature register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sig_q <= SEED;
    else         sig_q <= sig_d;
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/lib_sig_analyzer.sv
// Response compactor for the library tester: run FSM, count, compare.
// Optional idle-gap abort enabled by defining LIB_SA_TIMEOUT_EN.
module lib_sig_analyzer
  import lib_sa_pkg::*;
#(
  parameter int               SIG_W  = 16,
  parameter int               CNT_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(SA_POLY_DEF),
  parameter logic [SIG_W-1:0] SEED   = SIG_W'(SA_SEED_DEF),
  parameter int               TO_CYC = SA_TO_DEF
) (
  input  logic              iClk,
  input  logic              iClr,
  input  logic              iStart,
  input  logic [CNT_W-1:0]  iLen,
  input  logic [SIG_W-1:0]  iExpSig,
  input  logic              iValid,
  input  logic [RESP_W-1:0] iResp,
  output logic              oBusy,
  output logic              oDone,
  output logic              oPass,
  output logic [SIG_W-1:0]  oSig,
  output logic [CNT_W-1:0]  oCount,
  output logic              oTimeout
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [SIG_W-1:0] exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             to_q, to_d;
  logic             load;
  logic             absorb;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt_q + 1'b1;

`ifdef LIB_SA_TIMEOUT_EN
  localparam int GAP_W = $clog2(TO_CYC + 1);
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_inc;
  assign gap_inc = gap_q + 1'b1;
`else
  logic unused_to;
  assign unused_to = (TO_CYC > 0);
`endif

  lib_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk_i  (iClk),
    .rst_ni (iClr),
    .load_i (load),
    .en_i   (absorb),
    .data_i (iResp),
    .sig_o  (oSig)
  );

  // run sequencing: start, absorb, compare, report
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    to_d    = to_q;
    load    = 1'b0;
    absorb  = 1'b0;
`ifdef LIB_SA_TIMEOUT_EN
    gap_d   = gap_q;
`endif
    unique case (state_q)
      SA_IDLE: begin
        if (iStart) begin
          len_d  = iLen;
          exp_d  = iExpSig;
          cnt_d  = '0;
          pass_d = 1'b0;
          to_d   = 1'b0;
          load   = 1'b1;
`ifdef LIB_SA_TIMEOUT_EN
          gap_d  = '0;
`endif
          state_d = (iLen == '0) ? SA_CMP : SA_RUN;
        end
      end
      SA_RUN: begin
        if (iValid) begin
          absorb = 1'b1;
          cnt_d  = cnt_inc;
`ifdef LIB_SA_TIMEOUT_EN
          gap_d  = '0;
`endif
          if (cnt_inc == len_q)
            state_d = SA_CMP;
        end else begin
`ifdef LIB_SA_TIMEOUT_EN
          gap_d = gap_inc;
          if (gap_inc == GAP_W'(TO_CYC)) begin
            pass_d  = 1'b0;
            to_d    = 1'b1;
            state_d = SA_DONE;
          end
`endif
        end
      end
      SA_CMP: begin
        pass_d  = (oSig == exp_q);
        state_d = SA_DONE;
      end
      SA_DONE: begin
        state_d = SA_IDLE;
      end
      default: state_d = SA_IDLE;
    endcase
  end

  // control and result registers
  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) begin
      state_q <= SA_IDLE;
      len_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      to_q    <= to_d;
    end
  end

`ifdef LIB_SA_TIMEOUT_EN
  // consecutive idle-cycle counter
  always_ff @(posedge iClk or negedge iClr) begin
    if (!iClr) gap_q <= '0;
    else       gap_q <= gap_d;
  end
`endif

  assign oBusy    = (state_q == SA_RUN) || (state_q == SA_CMP);
  assign oDone    = (state_q == SA_DONE);
  assign oPass    = pass_q;
  assign oCount   = cnt_q;
  assign oTimeout = to_q;

endmodule

// File: tb/tb_lib_sig_analyzer.sv
// Directed self-checking bench for lib_sig_analyzer.
// Define LIB_SA_TIMEOUT_EN to exercise the idle-gap abort path.
module tb_lib_sig_analyzer;
  import lib_sa_pkg::*;

  logic        iClk = 1'b0;
  logic        iClr = 1'b0;
  logic        iStart = 1'b0;
  logic [7:0]  iLen = '0;
  logic [15:0] iExpSig = '0;
  logic        iValid = 1'b0;
  logic [4:0]  iResp = '0;
  logic        oBusy, oDone, oPass, oTimeout;
  logic [15:0] oSig;
  logic [7:0]  oCount;

  int n_chk  = 0;
  int n_fail = 0;

  lib_sig_analyzer dut (
    .iClk     (iClk),
    .iClr     (iClr),
    .iStart   (iStart),
    .iLen     (iLen),
    .iExpSig  (iExpSig),
    .iValid   (iValid),
    .iResp    (iResp),
    .oBusy    (oBusy),
    .oDone    (oDone),
    .oPass    (oPass),
    .oSig     (oSig),
    .oCount   (oCount),
    .oTimeout (oTimeout)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s,
                                       input logic [4:0] r);
    logic [15:0] n;
    n = {s[14:0], 1'b0};
    if (s[15]) n = n ^ 16'h1021;
    return n ^ {11'b0, r};
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start(input logic [7:0] len, input logic [15:0] e);
    iLen = len;
    iExpSig = e;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic sample(input logic [4:0] r);
    iValid = 1'b1;
    iResp = r;
    tick();
    iValid = 1'b0;
    iResp = '0;
  endtask

  logic [15:0] m;
  logic [4:0]  rv [5];

  initial begin
    #12;
    check("rst_sig", oSig, 16'hFFFF);
    check("rst_cnt", oCount, 0);
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_pass", oPass, 0);
    check("rst_to", oTimeout, 0);
    iClr = 1'b1;
    tick();

    // one sample, matching signature
    start(8'd1, 16'hEFCA);
    check("t1_busy", oBusy, 1);
    sample(5'b10101);
    check("t1_sig", oSig, 16'hEFCA);
    check("t1_cnt", oCount, 1);
    check("t1_nodone", oDone, 0);
    tick();
    check("t1_done", oDone, 1);
    check("t1_pass", oPass, 1);
    iStart = 1'b1;
    iLen = 8'd0;
    iExpSig = 16'hFFFF;
    tick();
    iStart = 1'b0;
    check("t1_done_clr", oDone, 0);
    check("t1_startdone", oBusy, 0);
    check("t1_hold", oPass, 1);

    // iValid in IDLE must not touch the signature
    sample(5'b11111);
    check("idle_sig", oSig, 16'hEFCA);

    // one sample, wrong signature
    start(8'd1, 16'hEFCA);
    check("t2_pclr", oPass, 0);
    sample(5'b00000);
    check("t2_sig", oSig, 16'hEFDF);
    tick();
    check("t2_done", oDone, 1);
    check("t2_pass", oPass, 0);
    tick();

    // zero length run
    start(8'd0, 16'hFFFF);
    check("t3_busy", oBusy, 1);
    check("t3_nodone", oDone, 0);
    tick();
    check("t3_done", oDone, 1);
    check("t3_pass", oPass, 1);
    check("t3_sig", oSig, 16'hFFFF);
    check("t3_cnt", oCount, 0);
    tick();

    // gapped run, start pulse and input changes during RUN ignored
    rv[0] = 5'h03; rv[1] = 5'h1C; rv[2] = 5'h09;
    m = 16'hFFFF;
    for (int i = 0; i < 3; i++) m = step(m, rv[i]);
    start(8'd3, m);
    iLen = 8'd9;
    iExpSig = 16'h0000;
    sample(rv[0]);
    check("t4_c1", oCount, 1);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    check("t4_c2", oCount, 1);
    tick();
    check("t4_c3", oCount, 1);
    check("t4_gapsig", oSig, step(16'hFFFF, rv[0]));
    sample(rv[1]);
    check("t4_c4", oCount, 2);
    sample(rv[2]);
    check("t4_c5", oCount, 3);
    check("t4_sig", oSig, m);
    tick();
    check("t4_done", oDone, 1);
    check("t4_pass", oPass, 1);
    tick();

    // asynchronous clear mid-run
    start(8'd5, 16'h1234);
    sample(5'h11);
    sample(5'h07);
    #2;
    iClr = 1'b0;
    #1;
    check("t5_busy", oBusy, 0);
    check("t5_sig", oSig, 16'hFFFF);
    check("t5_cnt", oCount, 0);
    check("t5_pass", oPass, 0);
    tick();
    iClr = 1'b1;
    tick();
    rv[0] = 5'h11; rv[1] = 5'h07; rv[2] = 5'h1F;
    rv[3] = 5'h00; rv[4] = 5'h0A;
    m = 16'hFFFF;
    for (int i = 0; i < 5; i++) m = step(m, rv[i]);
    start(8'd5, m);
    for (int i = 0; i < 5; i++) sample(rv[i]);
    check("t5_sig2", oSig, m);
    check("t5_cnt2", oCount, 5);
    tick();
    check("t5_done", oDone, 1);
    check("t5_pass2", oPass, 1);
    tick();

    // maximum length run
    m = 16'hFFFF;
    for (int i = 0; i < 255; i++) m = step(m, 5'(i));
    start(8'd255, m);
    for (int i = 0; i < 255; i++) sample(5'(i));
    check("t6_cnt", oCount, 8'hFF);
    check("t6_busy", oBusy, 1);
    tick();
    check("t6_done", oDone, 1);
    check("t6_pass", oPass, 1);
    tick();
    check("t6_cnthold", oCount, 8'hFF);

    // idle gap longer than the timeout limit
    start(8'd4, 16'h0000);
    sample(5'h01);
    sample(5'h02);
    for (int i = 0; i < 16; i++) tick();
`ifdef LIB_SA_TIMEOUT_EN
    check("t7_done", oDone, 1);
    check("t7_to", oTimeout, 1);
    check("t7_pass", oPass, 0);
    check("t7_cnt", oCount, 2);
    tick();
    check("t7_tohold", oTimeout, 1);
    start(8'd0, 16'hFFFF);
    check("t7_toclr", oTimeout, 0);
`else
    check("t7_busy", oBusy, 1);
    check("t7_nodone", oDone, 0);
    check("t7_to", oTimeout, 0);
    check("t7_cnt", oCount, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
